wb_reg_bridge: RTL
==================

Name: wb_reg_bridge

Overview:
Wishbone-classic slave to peripheral register-bus master bridge. It sits directly upstream of the UART/I2C/USB/SPI peripheral cluster and drives that cluster's reg_cs/reg_wr/reg_addr/reg_wdata/reg_be bus, consuming reg_rdata/reg_ack. It registers every request, decodes the illegal sub-block selects, enforces an ack timeout, and returns a single-cycle Wishbone ack or err.

Parameters:
TIMEOUT_CYC, 255, REQ cycles allowed before timeout; legal range 1..65535.
ERR_DATA, 32'hDEAD_DEAD, read data returned on decode or timeout error.
MAX_SEL, 3'd4, highest legal value of address bits [8:6]; larger values are a decode error.

Ports:
app_clk  input  1  clock
arst_n  input  1  asynchronous active-low reset
wbs_cyc_i  input  1  Wishbone cycle
wbs_stb_i  input  1  Wishbone strobe
wbs_we_i  input  1  write enable
wbs_adr_i  input  9  byte address
wbs_dat_i  input  32  write data
wbs_sel_i  input  4  byte select
wbs_dat_o  output  32  read data
wbs_ack_o  output  1  acknowledge
wbs_err_o  output  1  error
reg_cs  output  1  register-bus chip select
reg_wr  output  1  register-bus write
reg_addr  output  9  register-bus address
reg_wdata  output  32  register-bus write data
reg_be  output  4  register-bus byte enable
reg_rdata  input  32  register-bus read data
reg_ack  input  1  register-bus acknowledge
timeout_o  output  1  one-cycle pulse on each timeout
err_addr_o  output  9  address of the most recent error (decode or timeout)

Behaviour:
- Single clock domain (app_clk); reset is asynchronous, active-low (arst_n). All outputs are registered.
- Reset values: every output is 0, except wbs_dat_o, which is also 0. FSM resets to IDLE and the timeout counter to 0.
- Assertion of arst_n mid-transaction clears everything immediately. reg_cs drops asynchronously. No ack or err is issued for the lost transaction.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Sample wbs_cyc_i & wbs_stb_i. If low, stay in IDLE.
  - If high and wbs_adr_i[8:6] <= MAX_SEL: latch adr/we/dat/sel into reg_addr/reg_wr/reg_wdata/reg_be, set reg_cs=1, clear the counter, go to REQ. reg_cs is high the cycle after the strobe is sampled.
  - If high and wbs_adr_i[8:6] > MAX_SEL: reg_cs stays 0. Set wbs_dat_o=ERR_DATA and err_addr_o=adr, go to RESP with the error flag set.
- REQ:
  - reg_cs/reg_wr/reg_addr/reg_wdata/reg_be are held stable.
  - Counter increments each cycle that reg_ack is low.
  - reg_ack sampled high: capture reg_rdata into wbs_dat_o (for both reads and writes), drop reg_cs, go to RESP with the ok flag.
  - Counter reaches TIMEOUT_CYC-1 with reg_ack low: drop reg_cs, set wbs_dat_o=ERR_DATA, err_addr_o=reg_addr, pulse timeout_o for 1 cycle, go to RESP with the error flag.
  - If reg_ack and the timeout occur in the same cycle, the ack wins: no error.
- RESP:
  - Exactly one cycle: wbs_ack_o=1 (ok) or wbs_err_o=1 (error). Never both.
  - Gated by wbs_cyc_i: if the master dropped cyc during REQ (abort), neither is asserted. The downstream access still completes or times out; abort never truncates reg_cs.
  - Next state is IDLE.
- Latency: a zero-wait reg_ack (high in the first REQ cycle) gives Wishbone ack 3 cycles after the strobe is sampled. Decode error gives err 2 cycles after.
- Back-to-back: a strobe present in the first IDLE cycle after RESP is accepted. Minimum spacing between accesses is 3 cycles.
- reg_ack outside REQ is ignored.
- wbs_sel_i=0 is forwarded unchanged; it is not an error.
- wbs_dat_o holds its last value between transactions.
- err_addr_o holds its value until the next error.

Test Plan:
1. Write adr=9'h0C0, dat=32'h1234_5678, sel=4'hF; reg_ack asserted 2 cycles after reg_cs -> reg_cs high 3 cycles with reg_wr=1, reg_addr=9'h0C0, reg_wdata=32'h1234_5678; wbs_ack_o one cycle; wbs_err_o stays 0.
2. Read adr=9'h100; reg_rdata=32'hA5A5_0001 with zero-wait reg_ack -> wbs_ack_o 3 cycles after the strobe, wbs_dat_o=32'hA5A5_0001.
3. Read adr=9'h1C0 (sel 7) -> reg_cs never asserts; wbs_err_o one cycle, wbs_dat_o=32'hDEAD_DEAD, err_addr_o=9'h1C0.
4. TIMEOUT_CYC=8, reg_ack tied 0, read adr=9'h040 -> reg_cs high exactly 8 cycles; timeout_o one pulse; wbs_err_o one cycle; err_addr_o=9'h040. Repeat with reg_ack on the 8th cycle -> ack, no error.
5. wbs_cyc_i dropped during REQ, reg_ack after 4 cycles -> reg_cs held until ack; no wbs_ack_o and no wbs_err_o; next access proceeds normally.
6. arst_n pulsed low during REQ -> reg_cs and all outputs 0 immediately; FSM in IDLE after release; a new write completes normally.

Source files
------------

// File: rtl/wb_reg_bridge.sv
// Wishbone-classic slave to peripheral register-bus master bridge with
// sub-block decode check, downstream ack timeout and single-cycle ack/err.
//
// state | meaning
// IDLE  | waiting for cyc & stb; decodes the sub-block select
// REQ   | reg_cs held, waiting for reg_ack or the timeout
// RESP  | one cycle that raises wbs_ack_o or wbs_err_o (unless aborted)
module wb_reg_bridge #(
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_DEAD,
  parameter logic [2:0]  MAX_SEL     = 3'd4
) (
  input  logic        app_clk,
  input  logic        arst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [8:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        reg_cs,
  output logic        reg_wr,
  output logic [8:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  output logic        timeout_o,
  output logic [8:0]  err_addr_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [15:0] CNT_TC = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        err_flag;
  logic        abort;
  logic        accept, dec_ok, cnt_tc, req_to;
  logic        ack_nxt, err_nxt;

  always_comb begin
    accept = (state == IDLE) && wbs_cyc_i && wbs_stb_i;
    dec_ok = (wbs_adr_i[8:6] <= MAX_SEL);
    cnt_tc = (cnt == CNT_TC);
    req_to = (state == REQ) && !reg_ack && cnt_tc;
  end

  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = dec_ok ? REQ : RESP;
      REQ:     if (reg_ack || cnt_tc) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An abort seen during REQ, or cyc low in RESP, suppresses the response.
  always_comb begin
    ack_nxt = 1'b0;
    err_nxt = 1'b0;
    if (state == RESP && wbs_cyc_i && !abort) begin
      ack_nxt = !err_flag;
      err_nxt = err_flag;
    end
  end

  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      wbs_dat_o  <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_err_o  <= 1'b0;
      reg_cs     <= 1'b0;
      reg_wr     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_be     <= '0;
      timeout_o  <= 1'b0;
      err_addr_o <= '0;
      cnt        <= '0;
      err_flag   <= 1'b0;
      abort      <= 1'b0;
    end else begin
      wbs_ack_o <= ack_nxt;
      wbs_err_o <= err_nxt;
      timeout_o <= req_to;
      if (accept) begin
        abort <= 1'b0;
        if (dec_ok) begin
          reg_cs    <= 1'b1;
          reg_wr    <= wbs_we_i;
          reg_addr  <= wbs_adr_i;
          reg_wdata <= wbs_dat_i;
          reg_be    <= wbs_sel_i;
          cnt       <= '0;
          err_flag  <= 1'b0;
        end else begin
          wbs_dat_o  <= ERR_DATA;
          err_addr_o <= wbs_adr_i;
          err_flag   <= 1'b1;
        end
      end
      if (state == REQ) begin
        if (!wbs_cyc_i) abort <= 1'b1;
        // ack wins over a simultaneous terminal count
        if (reg_ack) begin
          reg_cs    <= 1'b0;
          wbs_dat_o <= reg_rdata;
          err_flag  <= 1'b0;
        end else if (cnt_tc) begin
          reg_cs     <= 1'b0;
          wbs_dat_o  <= ERR_DATA;
          err_addr_o <= reg_addr;
          err_flag   <= 1'b1;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

endmodule
